// File: rtl/pio_in_pkg.sv
// pio_in_pkg: register map and field encodings for the debounced input PIO
package pio_in_pkg;
   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_CONFIG  = 2'd1;
   localparam logic [1:0] ADDR_MASK    = 2'd2;
   localparam logic [1:0] ADDR_CAPTURE = 2'd3;
   typedef enum logic [1:0] {
      EDGE_ANY  = 2'b00,
      EDGE_RISE = 2'b01,
      EDGE_FALL = 2'b10,
      EDGE_BOTH = 2'b11
   } edge_type_e;
   localparam int IRQ_MODE_BIT = 0;
endpackage

// File: rtl/pio_in_debounced_if.sv
// pio_in_debounced_if: Avalon-MM slave port of the input PIO
interface pio_in_debounced_if;
   import pio_in_pkg::*;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   modport master (output address, chipselect, write_n, writedata, input readdata);
   modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/pio_debounce_bit.sv
// pio_debounce_bit: synchroniser, stability counter and edge detect for one input pin
module pio_debounce_bit
   import pio_in_pkg::*;
#(
   parameter int   SYNC_STAGES     = 2,
   parameter int   DEBOUNCE_CYCLES = 500000,
   parameter logic RESET_VAL       = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic in_bit,
   output logic deb,
   output logic rise,
   output logic fall
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
   logic [SYNC_STAGES-1:0] sr;
   logic [CW-1:0]          cnt;
   logic                   deb_d;
   logic                   sync;
   assign sync = sr[SYNC_STAGES-1];
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sr    <= {SYNC_STAGES{RESET_VAL}};
         cnt   <= '0;
         deb   <= RESET_VAL;
         deb_d <= RESET_VAL;
      end else begin
         sr    <= {sr[SYNC_STAGES-2:0], in_bit};
         deb_d <= deb;
         if (sync == deb) cnt <= '0;
         else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            deb <= sync;
            cnt <= '0;
         end else cnt <= cnt + 1'b1;
      end
   end
   assign rise = deb & ~deb_d;
   assign fall = ~deb & deb_d;
endmodule

// File: rtl/pio_in_debounced.sv
// pio_in_debounced: debounced input PIO with edge capture and edge/level irq
module pio_in_debounced
   import pio_in_pkg::*;
#(
   parameter int               WIDTH           = 4,
   parameter int               SYNC_STAGES     = 2,
   parameter int               DEBOUNCE_CYCLES = 500000,
   parameter logic [WIDTH-1:0] IN_RESET_VAL    = '0
) (
   input  logic                 clk,
   input  logic                 reset_n,
   pio_in_debounced_if.slave    bus,
   input  logic [WIDTH-1:0]     in_port,
   output logic                 irq
);
   logic [WIDTH-1:0] deb, rise, fall, mask, capture, event_bits, clr;
   logic [2:0]       cfg;
   logic [31:0]      rd_mux;
   logic             wr;
   logic             unused_wd;
   edge_type_e       etype;
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      pio_debounce_bit #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .RESET_VAL      (IN_RESET_VAL[i])
      ) u_bit (
         .clk    (clk),
         .reset_n(reset_n),
         .in_bit (in_port[i]),
         .deb    (deb[i]),
         .rise   (rise[i]),
         .fall   (fall[i])
      );
   end
   assign wr         = bus.chipselect & ~bus.write_n;
   assign etype      = edge_type_e'(cfg[2:1]);
   assign event_bits = etype == EDGE_RISE ? rise : etype == EDGE_FALL ? fall : rise | fall;
   assign clr        = (wr && bus.address == ADDR_CAPTURE) ? bus.writedata[WIDTH-1:0] : '0;
   assign irq        = cfg[IRQ_MODE_BIT] ? |(deb & mask) : |(capture & mask);
   assign unused_wd  = ^bus.writedata;
   always_comb
      rd_mux = bus.address == ADDR_DATA   ? 32'(deb) :
               bus.address == ADDR_CONFIG ? 32'(cfg) :
               bus.address == ADDR_MASK   ? 32'(mask) : 32'(capture);
   // a new event ORs in after the clear so a coincident W1C cannot drop it
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cfg          <= '0;
         mask         <= '0;
         capture      <= '0;
         bus.readdata <= '0;
      end else begin
         if (wr && bus.address == ADDR_CONFIG) cfg <= bus.writedata[2:0];
         if (wr && bus.address == ADDR_MASK) mask <= bus.writedata[WIDTH-1:0];
         capture      <= (capture & ~clr) | event_bits;
         bus.readdata <= rd_mux;
      end
   end
endmodule

// File: tb/tb_pio_in_debounced.sv
// tb_pio_in_debounced: vector table plus hand sequences for timing, collision, level irq and reset
module tb_pio_in_debounced;
   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [3:0] in_port = 4'h0;
   logic       irq;
   int         vectors = 0;
   int         errors = 0;
   pio_in_debounced_if bus();
   pio_in_debounced #(
      .WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .IN_RESET_VAL(4'h0)
   ) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus.slave), .in_port(in_port), .irq(irq)
   );
   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  pin;
      int          n;
      logic [31:0] exp_rd;
      logic        exp_irq;
   } vec_t;
   vec_t tbl[19];

   function automatic vec_t mk(logic wr, logic [1:0] a, logic [31:0] d, logic [3:0] p,
                               int n, logic [31:0] e, logic i);
      vec_t v;
      v.wr = wr; v.addr = a; v.wdata = d; v.pin = p; v.n = n; v.exp_rd = e; v.exp_irq = i;
      return v;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(logic wr, logic [1:0] a, logic [31:0] d);
      bus.chipselect = wr;
      bus.write_n    = ~wr;
      bus.address    = a;
      bus.writedata  = d;
   endtask

   task automatic write(logic [1:0] a, logic [31:0] d);
      drive(1'b1, a, d);
      tick();
      drive(1'b0, a, 32'h0);
   endtask

   initial begin
      // {wr, addr, wdata, pin, cycles, expected readdata after last edge, expected irq}
      tbl[0]  = mk(1'b0, 2'd0, 32'h0, 4'h0,  2, 32'h0, 1'b0);
      tbl[1]  = mk(1'b0, 2'd1, 32'h0, 4'h0,  2, 32'h0, 1'b0);
      tbl[2]  = mk(1'b0, 2'd2, 32'h0, 4'h0,  2, 32'h0, 1'b0);
      tbl[3]  = mk(1'b0, 2'd3, 32'h0, 4'h0,  2, 32'h0, 1'b0);
      tbl[4]  = mk(1'b1, 2'd2, 32'h1, 4'h0,  2, 32'h1, 1'b0);
      tbl[5]  = mk(1'b0, 2'd0, 32'h0, 4'h1, 10, 32'h1, 1'b1);
      tbl[6]  = mk(1'b0, 2'd3, 32'h0, 4'h1,  2, 32'h1, 1'b1);
      tbl[7]  = mk(1'b1, 2'd3, 32'h1, 4'h1,  2, 32'h0, 1'b0);
      tbl[8]  = mk(1'b0, 2'd0, 32'h0, 4'h3,  3, 32'h1, 1'b0);
      tbl[9]  = mk(1'b0, 2'd3, 32'h0, 4'h1, 10, 32'h0, 1'b0);
      tbl[10] = mk(1'b0, 2'd0, 32'h0, 4'h1,  2, 32'h1, 1'b0);
      tbl[11] = mk(1'b0, 2'd3, 32'h0, 4'h0, 10, 32'h1, 1'b1);
      tbl[12] = mk(1'b1, 2'd3, 32'hF, 4'h0,  2, 32'h0, 1'b0);
      tbl[13] = mk(1'b1, 2'd1, 32'h2, 4'h0,  2, 32'h2, 1'b0);
      tbl[14] = mk(1'b0, 2'd3, 32'h0, 4'h5, 10, 32'h5, 1'b1);
      tbl[15] = mk(1'b0, 2'd3, 32'h0, 4'h4, 10, 32'h5, 1'b1);
      tbl[16] = mk(1'b1, 2'd3, 32'h1, 4'h4,  2, 32'h4, 1'b0);
      tbl[17] = mk(1'b1, 2'd2, 32'h4, 4'h4,  2, 32'h4, 1'b1);
      tbl[18] = mk(1'b0, 2'd0, 32'h0, 4'h4,  2, 32'h4, 1'b1);

      drive(1'b0, 2'd0, 32'h0);
      #12;
      check("rd_in_reset", bus.readdata, 32'h0);
      check("irq_in_reset", {31'h0, irq}, 32'h0);
      tick();
      tick();
      reset_n = 1'b1;

      for (int k = 0; k < 19; k++) begin
         in_port = tbl[k].pin;
         drive(tbl[k].wr, tbl[k].addr, tbl[k].wdata);
         tick();
         drive(1'b0, tbl[k].addr, 32'h0);
         repeat (tbl[k].n - 1) tick();
         check($sformatf("vec%0d_rd", k), bus.readdata, tbl[k].exp_rd);
         check($sformatf("vec%0d_irq", k), {31'h0, irq}, {31'h0, tbl[k].exp_irq});
      end

      // edge-mode timing for a rising bit3: capture and irq exactly at edge 7
      write(2'd3, 32'hF);
      write(2'd2, 32'h8);
      bus.address = 2'd3;
      in_port = 4'hC;
      repeat (5) tick();
      check("edge_e5_irq", {31'h0, irq}, 32'h0);
      tick();
      check("edge_e6_irq", {31'h0, irq}, 32'h0);
      tick();
      check("edge_e7_irq", {31'h0, irq}, 32'h1);
      tick();
      check("edge_e8_capture", bus.readdata, 32'h8);

      // W1C of bit1 lands on the same edge its rise is captured
      in_port = 4'hE;
      repeat (6) tick();
      drive(1'b1, 2'd3, 32'h2);
      tick();
      drive(1'b0, 2'd3, 32'h0);
      tick();
      check("w1c_collision", bus.readdata, 32'hA);

      // level mode: irq follows deb[3]
      in_port = 4'h0;
      repeat (10) tick();
      write(2'd3, 32'hF);
      write(2'd1, 32'h1);
      write(2'd2, 32'h8);
      check("level_idle_irq", {31'h0, irq}, 32'h0);
      bus.address = 2'd0;
      in_port = 4'h8;
      repeat (5) tick();
      check("level_e5_irq", {31'h0, irq}, 32'h0);
      tick();
      check("level_e6_irq", {31'h0, irq}, 32'h1);
      in_port = 4'h0;
      repeat (5) tick();
      check("level_fall_e5_irq", {31'h0, irq}, 32'h1);
      tick();
      check("level_fall_e6_irq", {31'h0, irq}, 32'h0);
      bus.address = 2'd3;
      tick();
      tick();
      check("level_capture", bus.readdata, 32'h8);

      // async reset in the middle of a debounce
      write(2'd1, 32'h0);
      check("pre_reset_irq", {31'h0, irq}, 32'h1);
      bus.address = 2'd0;
      in_port = 4'h1;
      repeat (4) tick();
      reset_n = 1'b0;
      #1;
      check("async_rst_rd", bus.readdata, 32'h0);
      check("async_rst_irq", {31'h0, irq}, 32'h0);
      tick();
      tick();
      reset_n = 1'b1;
      bus.address = 2'd3;
      tick();
      check("rst_capture", bus.readdata, 32'h0);
      bus.address = 2'd0;
      repeat (4) tick();
      check("rst_deb_e5", bus.readdata, 32'h0);
      tick();
      check("rst_deb_e6", bus.readdata, 32'h0);
      tick();
      check("rst_deb_e7", bus.readdata, 32'h1);
      bus.address = 2'd1;
      tick();
      check("rst_config", bus.readdata, 32'h0);
      bus.address = 2'd2;
      tick();
      check("rst_mask", bus.readdata, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
